// File: rtl/uart_pkg.sv
// Shared constants for the uart echo path: transform modes, echo FSM states
// and the ASCII letter ranges used by the case-folding transforms.
package uart_pkg;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_UPPER  = 2'd1;
    localparam logic [1:0] MODE_LOWER  = 2'd2;
    localparam logic [1:0] MODE_INVERT = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        RELEASE   = 2'd2
    } echo_state_e;

    localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
    localparam logic [7:0] ASCII_UPPER_A    = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z    = 8'h5A;
    localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

    // Case folding on a single 8-bit character; non-letters pass unchanged.
    function automatic logic [7:0] ascii_fold(input logic [7:0] b, input logic [1:0] mode);
        logic [7:0] r;
        r = b;
        case (mode)
            MODE_UPPER: begin
                if ((b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z)) begin
                    r = b - ASCII_CASE_DELTA;
                end else begin
                    r = b;
                end
            end
            MODE_LOWER: begin
                if ((b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z)) begin
                    r = b + ASCII_CASE_DELTA;
                end else begin
                    r = b;
                end
            end
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on rd_data
// whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              push_s;
    logic              pop_s;

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == {(PTR_W + 1){1'b0}});
    assign push_s  = wr_en && !full;
    assign pop_s   = rd_en && !empty;
    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo bridge from uart RX to uart TX: buffers received bytes, applies the
// selected per-byte transform at pop time and hands them to the transmitter.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         rx_data,
    input  logic                      rx_rcvd,
    input  logic [1:0]                mode,
    input  logic                      clr_status,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_done,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      busy
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] fifo_rd_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [LVL_W-1:0]  fifo_count_s;
    logic [LVL_W-1:0]  level_next_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic              busy_s;

    echo_state_e       state_r;
    echo_state_e       state_s;
    logic [DATA_W-1:0] tx_data_r;
    logic [DATA_W-1:0] tx_data_s;
    logic              tx_start_r;
    logic              tx_start_s;
    logic              overflow_r;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic              busy_r;

    // Transform on the popped byte; case folding only has meaning for 8-bit data.
    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d, input logic [1:0] m);
        logic [DATA_W-1:0] r;
        r = d;
        case (m)
            MODE_INVERT: r = ~d;
            MODE_UPPER, MODE_LOWER: begin
                if (DATA_W == 8) begin
                    r = DATA_W'(ascii_fold(8'(d), m));
                end else begin
                    r = d;
                end
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Full is judged on the registered count, so a same-cycle pop never rescues a write.
    assign push_s = rx_rcvd && !fifo_full_s;
    assign drop_s = rx_rcvd && fifo_full_s;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (rx_data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Echo FSM next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        tx_start_s = tx_start_r;
        tx_data_s  = tx_data_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    tx_data_s  = xform(fifo_rd_data_s, mode);
                    tx_start_s = 1'b1;
                    state_s    = WAIT_DONE;
                end else begin
                    tx_start_s = 1'b0;
                    state_s    = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    tx_start_s = 1'b0;
                    state_s    = RELEASE;
                end else begin
                    tx_start_s = 1'b1;
                    state_s    = WAIT_DONE;
                end
            end
            RELEASE: begin
                tx_start_s = 1'b0;
                if (!tx_done) begin
                    state_s = IDLE;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                tx_start_s = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // Next-cycle occupancy, so busy can be registered without lagging the count.
    always_comb begin
        level_next_s = fifo_count_s;
        case ({push_s, pop_s})
            2'b10:   level_next_s = fifo_count_s + LVL_ONE;
            2'b01:   level_next_s = fifo_count_s - LVL_ONE;
            default: level_next_s = fifo_count_s;
        endcase
        busy_s = (state_s != IDLE) || (level_next_s != {LVL_W{1'b0}});
    end

    // FSM state and transmitter-facing registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            tx_start_r <= 1'b0;
            tx_data_r  <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tx_start_r <= tx_start_s;
            tx_data_r  <= tx_data_s;
            busy_r     <= busy_s;
        end
    end

    // Drop accounting; a clear in the same cycle as a drop takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_status) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != CNT_MAX) begin
                drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end
        end
    end

    assign tx_data    = tx_data_r;
    assign tx_start   = tx_start_r;
    assign fifo_level = fifo_count_s;
    assign overflow   = overflow_r;
    assign drop_cnt   = drop_cnt_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: stimulus queues expected TX bytes,
// a monitor compares each byte as the transmitter request rises.
module tb_uart_echo_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rcvd;
    logic [1:0] mode;
    logic       clr_status;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic [4:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int done_mode  = 0;   // 0: hold low, 1: auto handshake, 2: hold high
    int done_delay = 5;

    uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_rcvd    (rx_rcvd),
        .mode       (mode),
        .clr_status (clr_status),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b, input logic [7:0] e, input bit expect_it);
        rx_data = b;
        rx_rcvd = 1'b1;
        if (expect_it) exp_q.push_back(e);
        tick(1);
        rx_rcvd = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        tick(1);
    endtask

    // Checks the standard two-cycle echo latency for one byte already pushed.
    task automatic check_latency(input logic [7:0] e);
        @(negedge clk);
        check("lat_level_n1", 32'(fifo_level), 32'd1);
        check("lat_start_n1", 32'(tx_start), 32'd0);
        tick(1);
        @(negedge clk);
        check("lat_level_n2", 32'(fifo_level), 32'd0);
        check("lat_start_n2", 32'(tx_start), 32'd1);
        check("lat_data_n2", 32'(tx_data), 32'(e));
        tick(1);
    endtask

    // Transmitter model driving tx_done.
    initial begin : responder
        int cnt;
        cnt = 0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (done_mode)
                0: begin tx_done = 1'b0; cnt = 0; end
                2: begin tx_done = 1'b1; cnt = 0; end
                default: begin
                    if (tx_done) begin
                        if (!tx_start) tx_done = 1'b0;
                    end else if (tx_start) begin
                        cnt++;
                        if (cnt >= done_delay) begin
                            tx_done = 1'b1;
                            cnt = 0;
                        end
                    end
                end
            endcase
        end
    end

    // Scoreboard monitor: compares on each rising tx_start, then checks hold stability.
    initial begin : monitor
        logic       prev;
        logic [7:0] held;
        prev = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (tx_start && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: got 0x%0h with nothing expected", tx_data);
                    end else begin
                        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                    held = tx_data;
                end else if (tx_start) begin
                    check("tx_stable", 32'(tx_data), 32'(held));
                end
                prev = tx_start;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int n;
        rst = 1'b1;
        rx_data = 8'h00;
        rx_rcvd = 1'b0;
        mode = 2'd0;
        clr_status = 1'b0;
        tick(3);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(2);

        // Single echo, pass-through, with handshake timing.
        done_mode = 1;
        done_delay = 5;
        push(8'h41, 8'h41, 1'b1);
        check_latency(8'h41);
        @(negedge clk);
        n = 0;
        while (!tx_done && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(tx_done), 32'd1);
        check("start_with_done", 32'(tx_start), 32'd1);
        @(negedge clk);
        check("start_fall", 32'(tx_start), 32'd0);
        tick(1);
        wait_idle(20);

        // Burst ordering with the transmitter stalled.
        done_mode = 0;
        for (int i = 0; i < 16; i++) push(8'(i), 8'(i), 1'b1);
        check("burst_level", 32'(fifo_level), 32'd15);
        check("burst_overflow", 32'(overflow), 32'd0);
        done_mode = 1;
        done_delay = 2;
        wait_idle(400);
        check("burst_drops", 32'(drop_cnt), 32'd0);

        // Overflow accounting, saturation and clear priority.
        done_mode = 0;
        for (int i = 0; i < 20; i++) push(8'h80 + 8'(i), 8'h80 + 8'(i), i < 17);
        check("ovf_level", 32'(fifo_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop3", 32'(drop_cnt), 32'd3);
        check("ovf_start", 32'(tx_start), 32'd1);
        for (int i = 0; i < 300; i++) push(8'hFF, 8'hFF, 1'b0);
        check("ovf_saturate", 32'(drop_cnt), 32'd255);
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd16);
        rx_data = 8'hEE;
        rx_rcvd = 1'b1;
        clr_status = 1'b1;
        tick(1);
        rx_rcvd = 1'b0;
        clr_status = 1'b0;
        check("clr_wins_ovf", 32'(overflow), 32'd0);
        check("clr_wins_cnt", 32'(drop_cnt), 32'd0);
        push(8'hDD, 8'hDD, 1'b0);
        check("drop_again_ovf", 32'(overflow), 32'd1);
        check("drop_again_cnt", 32'(drop_cnt), 32'd1);
        check("drop_again_level", 32'(fifo_level), 32'd16);
        done_mode = 1;
        done_delay = 1;
        wait_idle(600);

        // Transforms.
        mode = 2'd1;
        push(8'h61, 8'h41, 1'b1);
        push(8'h7A, 8'h5A, 1'b1);
        push(8'h7B, 8'h7B, 1'b1);
        push(8'h31, 8'h31, 1'b1);
        push(8'h60, 8'h60, 1'b1);
        wait_idle(200);
        mode = 2'd2;
        push(8'h5A, 8'h7A, 1'b1);
        push(8'h41, 8'h61, 1'b1);
        push(8'h40, 8'h40, 1'b1);
        push(8'h5B, 8'h5B, 1'b1);
        wait_idle(200);
        mode = 2'd3;
        push(8'hA5, 8'h5A, 1'b1);
        wait_idle(50);
        mode = 2'd0;

        // Stale done level must not complete the second byte.
        done_mode = 2;
        tick(1);
        push(8'h11, 8'h11, 1'b1);
        push(8'h22, 8'h22, 1'b1);
        tick(10);
        check("stale_start", 32'(tx_start), 32'd0);
        check("stale_level", 32'(fifo_level), 32'd1);
        check("stale_busy", 32'(busy), 32'd1);
        done_mode = 1;
        done_delay = 2;
        wait_idle(100);

        // Asynchronous reset mid-transfer.
        done_mode = 0;
        for (int i = 1; i <= 5; i++) push(8'(i), 8'(i), 1'b1);
        @(negedge clk);
        check("pre_rst_level", 32'(fifo_level), 32'd4);
        check("pre_rst_start", 32'(tx_start), 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_start", 32'(tx_start), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        done_mode = 1;
        done_delay = 3;
        push(8'h5C, 8'h5C, 1'b1);
        check_latency(8'h5C);
        wait_idle(50);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
